// File: rtl/inst_fetch.sv
// Instruction fetch stage: word-addressed pc, BOOT/RUN/ERR sequencing and IF/ID pipeline register.
// Optional performance counters (fetch_cnt, stall_cnt) are built when IFETCH_PERF_CNT_EN is defined.
module inst_fetch #(
    parameter int unsigned IM_SIZE  = 100,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic [31:0] inst_in,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus1,
    output logic        if_id_valid,
    output logic        addr_err
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        IFID_HOLD    = 2'd0,
        IFID_CAPTURE = 2'd1,
        IFID_BUBBLE  = 2'd2
    } ifid_op_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus1;
    ifid_op_t    ifid_op;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        in_range;
    logic        stall_event;

    assign pc_plus1        = pc_q + 32'd1;
    assign redirect        = branch_taken_i | jump_i;
    // Branch outranks jump when both fire in the same cycle.
    assign redirect_target = branch_taken_i ? branch_target_i : jump_target_i;
    assign in_range        = (pc_q < IM_SIZE);

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ifid_op     = IFID_HOLD;
        stall_event = 1'b0;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    ifid_op = IFID_BUBBLE;
                end else if (stall_i) begin
                    stall_event = 1'b1;
                end else if (in_range) begin
                    pc_d    = pc_plus1;
                    ifid_op = IFID_CAPTURE;
                end else begin
                    state_d = ERR;
                    ifid_op = IFID_BUBBLE;
                end
            end
            ERR: begin
                ifid_op = IFID_BUBBLE;
                if (redirect) begin
                    pc_d    = redirect_target;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        // Flush wins over both capture and stall hold; pc sequencing is unaffected.
        if (flush_i) begin
            ifid_op = IFID_BUBBLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_inst     <= 32'd0;
            if_id_pc       <= 32'd0;
            if_id_pc_plus1 <= 32'd0;
            if_id_valid    <= 1'b0;
        end else begin
            case (ifid_op)
                IFID_CAPTURE: begin
                    if_id_inst     <= inst_in;
                    if_id_pc       <= pc_q;
                    if_id_pc_plus1 <= pc_plus1;
                    if_id_valid    <= 1'b1;
                end
                IFID_BUBBLE: begin
                    // Bubble keeps the pc fields of the last instruction.
                    if_id_inst  <= 32'd0;
                    if_id_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (ifid_op == IFID_CAPTURE) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (stall_event) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

    assign pc_out   = pc_q;
    assign addr_err = (state_q == ERR);

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter IM_SIZE, default 100, instruction memory depth in words; legal pc range 0..IM_SIZE-1.
REQ-002 Parameter RESET_PC, default 32'd0, pc value loaded at reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 stall_i  input  1  hold fetch; pc and IF/ID register keep their values.
REQ-006 flush_i  input  1  replace the IF/ID contents with a bubble on this edge.
REQ-007 branch_taken_i  input  1  redirect pc to branch_target_i.
REQ-008 branch_target_i  input  32  branch word address.
REQ-009 jump_i  input  1  redirect pc to jump_target_i.
REQ-010 jump_target_i  input  32  jump word address.
REQ-011 inst_in  input  32  instruction word returned combinationally by the instruction memory for pc_out.
REQ-012 pc_out  output  32  current word address driven to the instruction memory.
REQ-013 if_id_inst  output  32  registered instruction; 32'd0 (NOP) when invalid.
REQ-014 if_id_pc  output  32  registered pc of if_id_inst.
REQ-015 if_id_pc_plus1  output  32  registered if_id_pc+1.
REQ-016 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-017 addr_err  output  1  high while the FSM is in ERR.

Function
REQ-018 pc is word-addressed; sequential next pc = pc+1, 32-bit modulo 2^32.
REQ-019 FSM states: BOOT, RUN, ERR; BOOT lasts exactly one cycle after rst_n deasserts, captures nothing, and holds pc, then goes to RUN.
REQ-020 Redirect priority: branch_taken_i > jump_i > stall_i > sequential; a redirect overrides stall_i.
REQ-021 RUN, redirect: pc <= target; IF/ID <= bubble (valid=0, inst=0, pc fields held).
REQ-022 RUN, stall_i without redirect: pc and all IF/ID outputs hold.
REQ-023 RUN, no stall and no redirect, pc < IM_SIZE: IF/ID <= {inst_in, pc, pc+1, valid=1}; pc <= pc+1; latency pc_out -> if_id_inst is one cycle.
REQ-024 RUN, no stall and no redirect, pc >= IM_SIZE: go to ERR; IF/ID <= bubble; pc holds.
REQ-025 ERR: pc holds; IF/ID stays a bubble; stall_i is ignored; a redirect loads the target into pc and returns the FSM to RUN.
REQ-026 flush_i forces the IF/ID bubble on that edge in every state, overriding both capture and stall hold; pc follows REQ-020..025 unchanged.
REQ-027 A redirect to a target >= IM_SIZE is accepted; ERR is entered when that pc would be captured.

Reset
REQ-028 On rst_n low: pc_out=RESET_PC, if_id_inst=0, if_id_pc=0, if_id_pc_plus1=0, if_id_valid=0, addr_err=0, state=BOOT, counters=0; reset applies immediately and mid-operation.

Configuration
REQ-029 Macro IFETCH_PERF_CNT_EN: when defined, adds outputs fetch_cnt[31:0] and stall_cnt[31:0].
REQ-030 fetch_cnt increments on every valid IF/ID capture; stall_cnt increments on every RUN cycle with stall_i=1 and no redirect; both wrap modulo 2^32.
REQ-031 Without IFETCH_PERF_CNT_EN, the counter ports and logic are absent and all other behaviour is identical.

Verification
REQ-032 Reset release with IM_SIZE=100 and inst_in=mem[pc]: one BOOT cycle, then pc_out 0,1,2,...; if_id_pc=0 with if_id_inst=mem[0] one cycle after pc_out=0.
REQ-033 stall_i high for 3 cycles at pc=5: pc_out stays 5 and IF/ID holds mem[4] for 3 cycles; stall_cnt +3 when the macro is defined.
REQ-034 branch_taken_i=1, target=40, with jump_i=1 and stall_i=1 in the same cycle: next pc_out=40, if_id_valid=0, then mem[40] is captured.
REQ-035 Sequential run to pc=100: addr_err=1, if_id_valid=0, pc_out holds 100; jump_i to 10 -> RUN with pc_out=10, addr_err=0.
REQ-036 rst_n asserted mid-run at pc=57 with flush_i=1: all outputs immediately return to reset values; a single-cycle flush_i in RUN gives exactly one bubble while pc continues advancing.
